// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder/encoder family: handshake FSM states,
// the 2-bit output codes and a small population-count helper.
package decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [1:0] CODE_D0 = 2'b00;
    localparam logic [1:0] CODE_D1 = 2'b01;
    localparam logic [1:0] CODE_D2 = 2'b10;
    localparam logic [1:0] CODE_D3 = 2'b11;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/prio_pick4.sv
// Combinational 4-way picker: first set candidate at or after startIdx_i,
// wrapping 3->0, plus "any" and "more than one candidate" flags.
module prio_pick4
    import decoder_pkg::*;
(
    input  logic [3:0] cand_i,
    input  logic [1:0] startIdx_i,
    output logic [1:0] idx_o,
    output logic       any_o,
    output logic       multi_o
);

    logic [1:0] probe;
    logic       found;

    // Walk the four positions in rotated order and keep the first hit.
    always_comb begin
        idx_o = startIdx_i;
        found = 1'b0;
        probe = startIdx_i;
        for (int k = 0; k < 4; k++) begin
            probe = startIdx_i + 2'(k);
            if (!found && cand_i[probe]) begin
                idx_o = probe;
                found = 1'b1;
            end
        end
    end

    assign any_o   = |cand_i;
    assign multi_o = (popcount4(cand_i) >= 3'd2);

endmodule

// File: rtl/encoder_4to2_hs.sv
// 4-to-2 priority encoder with request capture and a valid/ready handshake.
// ROUND_ROBIN=0 gives D0 highest priority; ROUND_ROBIN=1 rotates after each grant.
module encoder_4to2_hs
    import decoder_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic EN,
    input  logic READY,
    output logic A0,
    output logic A1,
    output logic VALID,
    output logic MULTI
);

    state_e     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] code_q, code_d;
    logic       multi_q;
    logic [1:0] ptr_q;

    logic [3:0] reqMasked;
    logic [3:0] candidates;
    logic [3:0] selOneHot;
    logic [1:0] startIdx;
    logic [1:0] pickIdx;
    logic       pickAny;
    logic       pickMulti;
    logic       loadCode;

    assign reqMasked  = {D3, D2, D1, D0} & {4{EN}};
    assign candidates = pending_q | reqMasked;
    assign startIdx   = ROUND_ROBIN ? (ptr_q + 2'd1) : 2'd0;

    prio_pick4 u_pick (
        .cand_i     (candidates),
        .startIdx_i (startIdx),
        .idx_o      (pickIdx),
        .any_o      (pickAny),
        .multi_o    (pickMulti)
    );

    // The granted request is consumed by the load; a request arriving during
    // HOLD for the in-flight index lands in pending and earns a fresh grant.
    assign selOneHot = 4'b0001 << pickIdx;
    assign pending_d = loadCode ? (candidates & ~selOneHot) : candidates;

    always_comb begin
        code_d = CODE_D0;
        case (pickIdx)
            2'd0:    code_d = CODE_D0;
            2'd1:    code_d = CODE_D1;
            2'd2:    code_d = CODE_D2;
            default: code_d = CODE_D3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Acceptance and the next load share one edge, so there is no bubble.
    always_comb begin
        state_d  = state_q;
        loadCode = 1'b0;
        case (state_q)
            IDLE: begin
                if (pickAny) begin
                    loadCode = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (READY) begin
                    if (pickAny) begin
                        loadCode = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        VALID = (state_q == HOLD);
        A0    = code_q[1];
        A1    = code_q[0];
        MULTI = multi_q;
    end

    // Pointer resets to 3 so the first rotating search begins at D0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 4'b0000;
            code_q    <= CODE_D0;
            multi_q   <= 1'b0;
            ptr_q     <= 2'd3;
        end else begin
            pending_q <= pending_d;
            if (loadCode) begin
                code_q  <= code_d;
                multi_q <= pickMulti;
                ptr_q   <= pickIdx;
            end
        end
    end

endmodule

// File: tb/tb_encoder_4to2_hs.sv
// Bench for encoder_4to2_hs: a fixed-priority and a round-robin instance share
// stimulus; a queue-free behavioural model is compared every cycle.
module tb_encoder_4to2_hs;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic       en;
    logic       ready;
    logic [1:0] a0Out, a1Out, validOut, multiOut;

    int  checkCount = 0;
    int  failCount  = 0;
    bit  checking   = 1'b0;

    encoder_4to2_hs #(.ROUND_ROBIN(1'b0)) dutFixed (
        .clk(clk), .rst_n(rst_n),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .EN(en), .READY(ready),
        .A0(a0Out[0]), .A1(a1Out[0]), .VALID(validOut[0]), .MULTI(multiOut[0])
    );

    encoder_4to2_hs #(.ROUND_ROBIN(1'b1)) dutRr (
        .clk(clk), .rst_n(rst_n),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .EN(en), .READY(ready),
        .A0(a0Out[1]), .A1(a1Out[1]), .VALID(validOut[1]), .MULTI(multiOut[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a set of outstanding requests, one held code, and the last grant.
    bit       mPend  [2][4];
    bit       mValid [2];
    int       mCode  [2];
    bit       mMulti [2];
    int       mLast  [2];
    bit       cand   [4];
    int       nCand, startPos, pick, pos;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 4; i++) mPend[m][i] = 1'b0;
                mValid[m] = 1'b0;
                mCode[m]  = 0;
                mMulti[m] = 1'b0;
                mLast[m]  = 3;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                nCand = 0;
                for (int i = 0; i < 4; i++) begin
                    cand[i] = mPend[m][i] || (d[i] && en);
                    if (cand[i]) nCand++;
                end
                if (!mValid[m] || ready) begin
                    if (nCand > 0) begin
                        startPos = (m == 1) ? (mLast[m] + 1) % 4 : 0;
                        pick = -1;
                        for (int k = 0; k < 4; k++) begin
                            pos = (startPos + k) % 4;
                            if (pick < 0 && cand[pos]) pick = pos;
                        end
                        mValid[m] = 1'b1;
                        mCode[m]  = pick;
                        mMulti[m] = (nCand >= 2);
                        mLast[m]  = pick;
                        cand[pick] = 1'b0;
                    end else begin
                        mValid[m] = 1'b0;
                    end
                end
                for (int i = 0; i < 4; i++) mPend[m][i] = cand[i];
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (checking) begin
            for (int m = 0; m < 2; m++) begin
                checkCount++;
                if (validOut[m] !== mValid[m]) begin
                    failCount++;
                    $display("[TB] FAIL model VALID inst%0d t=%0t: got %b expected %b",
                             m, $time, validOut[m], mValid[m]);
                end
                if (mValid[m] || !rst_n) begin
                    checkCount++;
                    if ({a0Out[m], a1Out[m]} !== 2'(mCode[m]) || multiOut[m] !== mMulti[m]) begin
                        failCount++;
                        $display("[TB] FAIL model CODE/MULTI inst%0d t=%0t: got %b%b/%b expected %0d/%b",
                                 m, $time, a0Out[m], a1Out[m], multiOut[m], mCode[m], mMulti[m]);
                    end
                end
            end
        end
    end

    // Drive inputs at a falling edge and hold them through one rising edge.
    task automatic applyStimulus(input logic [3:0] dv, input logic env, input logic rdy);
        d     = dv;
        en    = env;
        ready = rdy;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int inst, input logic expValid,
                               input logic [1:0] expCode, input logic expMulti);
        checkCount++;
        if (validOut[inst] !== expValid ||
            (expValid && ({a0Out[inst], a1Out[inst]} !== expCode || multiOut[inst] !== expMulti))) begin
            failCount++;
            $display("[TB] FAIL %s inst%0d: got V=%b code=%b%b M=%b expected V=%b code=%b M=%b",
                     name, inst, validOut[inst], a0Out[inst], a1Out[inst], multiOut[inst],
                     expValid, expCode, expMulti);
        end
    endtask

    task automatic checkReset(input string name);
        for (int m = 0; m < 2; m++) begin
            checkCount++;
            if ({validOut[m], a0Out[m], a1Out[m], multiOut[m]} !== 4'b0000) begin
                failCount++;
                $display("[TB] FAIL %s inst%0d: got V/A0/A1/M=%b%b%b%b expected 0000",
                         name, m, validOut[m], a0Out[m], a1Out[m], multiOut[m]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d     = 4'b0000;
        en    = 1'b0;
        ready = 1'b0;
        #2;
        checkReset("power_on_reset");
        checking = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("idle_after_reset", 0, 1'b0, 2'b00, 1'b0);

        // D1 and D3 together for one cycle: 01 with MULTI, then 11, then idle.
        applyStimulus(4'b1010, 1'b1, 1'b1);
        checkOutput("fixed_first_01", 0, 1'b1, 2'b01, 1'b1);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("fixed_second_11", 0, 1'b1, 2'b11, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("fixed_drained", 0, 1'b0, 2'b00, 1'b0);

        // Backpressure with a re-pulse of D2 while the first 10 is held.
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("bp_load_10", 0, 1'b1, 2'b10, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus((c == 2) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
            checkOutput("bp_held_10", 0, 1'b1, 2'b10, 1'b0);
        end
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("bp_second_10", 0, 1'b1, 2'b10, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("bp_drained", 0, 1'b0, 2'b00, 1'b0);

        // EN low blocks D0 while an earlier pending D3 still drains.
        applyStimulus(4'b0100, 1'b1, 1'b0);
        applyStimulus(4'b1000, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("en_hold_10", 0, 1'b1, 2'b10, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b1);
        checkOutput("en_drain_11", 0, 1'b1, 2'b11, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b1);
        checkOutput("en_blocked_idle", 0, 1'b0, 2'b00, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("en_blocked_idle_rr", 1, 1'b0, 2'b00, 1'b0);

        // D1 re-asserted on the edge its 01 is accepted yields a second 01.
        applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("collide_first_01", 0, 1'b1, 2'b01, 1'b0);
        applyStimulus(4'b0010, 1'b1, 1'b1);
        checkOutput("collide_second_01", 0, 1'b1, 2'b01, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("collide_drained", 0, 1'b0, 2'b00, 1'b0);

        // Reset asserted mid-HOLD clears outputs without a clock edge.
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("pre_reset_10", 0, 1'b1, 2'b10, 1'b0);
        applyStimulus(4'b1000, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkReset("async_reset_midhold");
        d  = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("pending_empty_after_reset", 0, 1'b0, 2'b00, 1'b0);
        checkOutput("pending_empty_after_reset_rr", 1, 1'b0, 2'b00, 1'b0);

        // Rotating priority with all requests held high.
        applyStimulus(4'b1111, 1'b1, 1'b1);
        checkOutput("rr_00", 1, 1'b1, 2'b00, 1'b1);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        checkOutput("rr_01", 1, 1'b1, 2'b01, 1'b1);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        checkOutput("rr_10", 1, 1'b1, 2'b10, 1'b1);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        checkOutput("rr_11", 1, 1'b1, 2'b11, 1'b1);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        checkOutput("rr_wrap_00", 1, 1'b1, 2'b00, 1'b1);
        checkOutput("fixed_d0_dominates", 0, 1'b1, 2'b00, 1'b1);

        for (int c = 0; c < 6; c++) applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("final_idle_fixed", 0, 1'b0, 2'b00, 1'b0);
        checkOutput("final_idle_rr", 1, 1'b0, 2'b00, 1'b0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
